// File: rtl/key_event_ctrl_if.sv
// Event handshake between key_event_ctrl (master) and its consumer (slave).
interface key_event_ctrl_if;
    logic       ev_valid;
    logic [5:0] ev_code;
    logic       ev_ready;
    logic [4:0] ev_level;

    modport master (output ev_valid, output ev_code, output ev_level, input ev_ready);
    modport slave  (input ev_valid, input ev_code, input ev_level, output ev_ready);
endinterface

// File: rtl/key_event_ctrl.sv
// Samples the key_scan rows on a tick, debounces the 32 keys serially and queues events.
// Optional macro KEY_RELEASE_EVENTS_EN: when defined, release events are queued too.
module key_event_ctrl #(
    parameter int unsigned TICK_DIV       = 1000,
    parameter int unsigned DEBOUNCE_TICKS = 4,
    parameter int unsigned FIFO_DEPTH     = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              key_row1,
    input  logic [7:0]              key_row2,
    input  logic [7:0]              key_row3,
    input  logic [7:0]              key_row4,
    key_event_ctrl_if.master        ev,
    output logic                    overflow,
    input  logic                    clr_overflow,
    output logic [31:0]             keys_stable
);
    localparam int unsigned TW = $clog2(TICK_DIV);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam logic [TW-1:0] TickLast  = TW'(TICK_DIV - 1);
    localparam logic [3:0]    DbLast    = 4'(DEBOUNCE_TICKS - 1);
    localparam logic [4:0]    FullLevel = 5'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StSnap, StWalk} state_e;

    state_e          state_q, state_d;
    logic [TW-1:0]   tcnt_q;
    logic [31:0]     snap_q;
    logic [4:0]      idx_q;
    logic [3:0]      dcnt_q [32];
    logic [31:0]     keys_stable_q;
    logic [5:0]      mem_q [FIFO_DEPTH];
    logic [PW-1:0]   wptr_q, rptr_q;
    logic [4:0]      level_q;
    logic            overflow_q;

    logic            tick;
    logic            cur_snap, cur_stable, key_accept, ev_gen;
    logic [3:0]      cur_dcnt;
    logic            push, pop, full, drop;

    assign tick       = (tcnt_q == TickLast);
    assign cur_snap   = snap_q[idx_q];
    assign cur_stable = keys_stable_q[idx_q];
    assign cur_dcnt   = dcnt_q[idx_q];

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (tick) state_d = StSnap;
            StSnap:  state_d = StWalk;
            StWalk:  if (idx_q == 5'd31) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        key_accept = (state_q == StWalk) && (cur_snap != cur_stable) && (cur_dcnt == DbLast);
`ifdef KEY_RELEASE_EVENTS_EN
        ev_gen = key_accept;
`else
        // Releases still update keys_stable but never reach the FIFO.
        ev_gen = key_accept && cur_snap;
`endif
        full = (level_q == FullLevel);
        pop  = (level_q != 5'd0) && ev.ev_ready;
        push = ev_gen && (!full || pop);
        drop = ev_gen && full && !pop;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            tcnt_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tick ? '0 : tcnt_q + TW'(1);
            if (state_q == StSnap) begin
                idx_q <= '0;
            end else if (state_q == StWalk) begin
                idx_q <= idx_q + 5'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == StSnap) begin
            snap_q <= {key_row1, key_row2, key_row3, key_row4};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            keys_stable_q <= '0;
            for (int i = 0; i < 32; i++) begin
                dcnt_q[i] <= '0;
            end
        end else if (state_q == StWalk) begin
            if (cur_snap == cur_stable) begin
                dcnt_q[idx_q] <= '0;
            end else if (cur_dcnt == DbLast) begin
                keys_stable_q[idx_q] <= cur_snap;
                dcnt_q[idx_q]        <= '0;
            end else begin
                dcnt_q[idx_q] <= cur_dcnt + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= {cur_snap, idx_q};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wptr_q <= wptr_q + PW'(1);
            if (pop)  rptr_q <= rptr_q + PW'(1);
            level_q <= level_q + 5'(push) - 5'(pop);
            // A drop in the same cycle as a clear keeps the flag set.
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (clr_overflow) begin
                overflow_q <= 1'b0;
            end
        end
    end

    assign ev.ev_valid  = (level_q != 5'd0);
    assign ev.ev_code   = ev.ev_valid ? mem_q[rptr_q] : 6'd0;
    assign ev.ev_level  = level_q;
    assign overflow     = overflow_q;
    assign keys_stable  = keys_stable_q;

endmodule

// File: tb/tb_key_event_ctrl.sv
// Scoreboard bench for key_event_ctrl: expected events queued at stimulus, popped by a monitor.
module tb_key_event_ctrl;
    localparam int unsigned TickDiv = 40;
    localparam int unsigned Depth   = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  key_row1 = '0, key_row2 = '0, key_row3 = '0, key_row4 = '0;
    logic        overflow;
    logic        clr_overflow = 1'b0;
    logic [31:0] keys_stable;

    int          checks = 0;
    int          errors = 0;
    logic [5:0]  exp_q [$];
    logic [5:0]  exp_code;

    key_event_ctrl_if kif ();

    key_event_ctrl #(
        .TICK_DIV       (TickDiv),
        .DEBOUNCE_TICKS (4),
        .FIFO_DEPTH     (Depth)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_row1     (key_row1),
        .key_row2     (key_row2),
        .key_row3     (key_row3),
        .key_row4     (key_row4),
        .ev           (kif),
        .overflow     (overflow),
        .clr_overflow (clr_overflow),
        .keys_stable  (keys_stable)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_rows(input logic [31:0] v);
        {key_row1, key_row2, key_row3, key_row4} = v;
    endtask

    // Monitor: every accepted event must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && kif.ev_valid && kif.ev_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: got %0h expected none", kif.ev_code);
            end else begin
                exp_code = exp_q.pop_front();
                if (kif.ev_code !== exp_code) begin
                    errors++;
                    $display("FAIL event_code: got %0h expected %0h", kif.ev_code, exp_code);
                end
            end
        end
    end

    initial begin
        kif.ev_ready = 1'b1;
        cyc(3);
        rst_n = 1'b1;
        chk("rst_ev_valid", {31'd0, kif.ev_valid}, 32'd0);
        chk("rst_ev_code", {26'd0, kif.ev_code}, 32'd0);
        chk("rst_ev_level", {27'd0, kif.ev_level}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        chk("rst_keys_stable", keys_stable, 32'd0);

        // Single press of index 5
        exp_q.push_back(6'b1_00101);
        set_rows(32'h0000_0020);
        cyc(5 * TickDiv);
        chk("press5_stable", keys_stable, 32'h0000_0020);
        chk("press5_drained", exp_q.size(), 32'd0);

        // Index 31 for 3 samples, twice, with a gap: never accepted
        set_rows(32'h8000_0020);
        cyc(3 * TickDiv);
        set_rows(32'h0000_0020);
        cyc(2 * TickDiv);
        set_rows(32'h8000_0020);
        cyc(3 * TickDiv);
        set_rows(32'h0000_0020);
        cyc(5 * TickDiv);
        chk("glitch31_stable", keys_stable, 32'h0000_0020);
        chk("glitch31_level", {27'd0, kif.ev_level}, 32'd0);

        // Indices 3 and 20 together, consumer stalled
        kif.ev_ready = 1'b0;
        exp_q.push_back(6'b1_00011);
        exp_q.push_back(6'b1_10100);
        set_rows(32'h0010_0028);
        cyc(5 * TickDiv);
        chk("pair_level", {27'd0, kif.ev_level}, 32'd2);
        chk("pair_valid", {31'd0, kif.ev_valid}, 32'd1);
        chk("pair_head_held", {26'd0, kif.ev_code}, 32'h23);
        kif.ev_ready = 1'b1;
        cyc(10);
        chk("pair_drained_level", {27'd0, kif.ev_level}, 32'd0);
        chk("pair_stable", keys_stable, 32'h0010_0028);

        // Release all three
        kif.ev_ready = 1'b0;
`ifdef KEY_RELEASE_EVENTS_EN
        exp_q.push_back(6'b0_00011);
        exp_q.push_back(6'b0_00101);
        exp_q.push_back(6'b0_10100);
`endif
        set_rows(32'h0000_0000);
        cyc(5 * TickDiv);
`ifdef KEY_RELEASE_EVENTS_EN
        chk("release_level", {27'd0, kif.ev_level}, 32'd3);
`else
        chk("release_level", {27'd0, kif.ev_level}, 32'd0);
`endif
        chk("release_stable", keys_stable, 32'd0);
        kif.ev_ready = 1'b1;
        cyc(10);
        chk("release_drained", exp_q.size(), 32'd0);

        // Six keys into a depth-4 FIFO: only the four lowest indices survive
        kif.ev_ready = 1'b0;
        exp_q.push_back(6'b1_00000);
        exp_q.push_back(6'b1_00001);
        exp_q.push_back(6'b1_01000);
        exp_q.push_back(6'b1_01001);
        set_rows(32'h0101_0303);
        cyc(5 * TickDiv);
        chk("ovf_level", {27'd0, kif.ev_level}, 32'd4);
        chk("ovf_flag", {31'd0, overflow}, 32'd1);
        chk("ovf_stable", keys_stable, 32'h0101_0303);
        clr_overflow = 1'b1;
        cyc(1);
        clr_overflow = 1'b0;
        chk("ovf_cleared", {31'd0, overflow}, 32'd0);
        kif.ev_ready = 1'b1;
        cyc(10);
        chk("ovf_drained", exp_q.size(), 32'd0);

        // Reset during a walk with two events pending
        set_rows(32'h0000_0000);
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        kif.ev_ready = 1'b0;
        set_rows(32'h0010_0008);
        for (int i = 0; i < 8 * TickDiv && kif.ev_level != 5'd2; i++) cyc(1);
        chk("midwalk_level2", {27'd0, kif.ev_level}, 32'd2);
        rst_n = 1'b0;
        cyc(1);
        chk("midwalk_valid", {31'd0, kif.ev_valid}, 32'd0);
        chk("midwalk_level", {27'd0, kif.ev_level}, 32'd0);
        chk("midwalk_stable", keys_stable, 32'd0);
        rst_n = 1'b1;
        exp_q.delete();
        // Walk restarts from idle: the held keys are re-debounced from scratch
        exp_q.push_back(6'b1_00011);
        exp_q.push_back(6'b1_10100);
        kif.ev_ready = 1'b1;
        cyc(6 * TickDiv);
        chk("after_reset_stable", keys_stable, 32'h0010_0008);
        chk("after_reset_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
